// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// base opcodes and the datapath mux-select codes the controller drives.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RD1    = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUREG  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALUOUT  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared
// datapath one instruction at a time, handshaking every memory access.
module multicycle_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       pc_en,
  output logic       ir_en,
  output logic       data_en,
  output logic       rd_en,
  output logic       alu_en,
  output logic       reg_we,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal
);

  // A build with RESET_STATE_FETCH=0 parks in TRAP as a halt.
  localparam state_t RST_STATE = (RESET_STATE_FETCH != 0) ? S_FETCH : S_TRAP;

  state_t state;

  // funct7b5 is consumed by the ALU decoder in the datapath.
  logic unused_funct7b5;
  assign unused_funct7b5 = funct7b5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
    end else begin
      case (state)
        S_FETCH:     if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEM_ADR;
            OP_R:              state <= S_EXEC_R;
            OP_I:              state <= S_EXEC_I;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            default:           state <= S_TRAP;
          endcase
        end
        S_MEM_ADR:   state <= opcode[5] ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
        S_MEM_WB:    state <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
        S_EXEC_R,
        S_EXEC_I,
        S_JAL:       state <= S_ALU_WB;
        S_ALU_WB,
        S_BRANCH:    state <= S_FETCH;
        default:     state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    data_en    = 1'b0;
    rd_en      = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUREG;
    alu_op     = ALUOP_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        ir_en      = mem_ready;
        pc_en      = mem_ready;
      end
      S_DECODE: begin
        rd_en     = 1'b1;
        alu_en    = 1'b1;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_ADR: begin
        alu_en    = 1'b1;
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        data_en = mem_ready;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        result_src = RES_DATA;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        retire  = mem_ready;
      end
      S_EXEC_R: begin
        alu_en    = 1'b1;
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_en    = 1'b1;
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_SUB;
        retire    = 1'b1;
        case (funct3)
          3'b000:  pc_en = zero;
          3'b001:  pc_en = ~zero;
          default: pc_en = 1'b0;
        endcase
      end
      S_JAL: begin
        pc_en     = 1'b1;
        alu_en    = 1'b1;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    // Reset kills any in-flight request and every write enable immediately.
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      pc_en   = 1'b0;
      ir_en   = 1'b0;
      data_en = 1'b0;
      rd_en   = 1'b0;
      alu_en  = 1'b0;
      reg_we  = 1'b0;
      retire  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: per-instruction expected output
// schedules built from the instruction class and chosen memory wait counts.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       mem_req, mem_we, adr_src, pc_en, ir_en, data_en, rd_en, alu_en, reg_we;
    logic [1:0] a, b, rs, op;
    logic       retire, illegal;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, pc_en, ir_en, data_en, rd_en, alu_en, reg_we;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       retire, illegal;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int cnt = 0;
  int last_len = -1;

  multicycle_ctrl_fsm #(.RESET_STATE_FETCH(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .pc_en(pc_en), .ir_en(ir_en), .data_en(data_en), .rd_en(rd_en),
    .alu_en(alu_en), .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  ov_t act;
  assign act = {mem_req, mem_we, adr_src, pc_en, ir_en, data_en, rd_en, alu_en, reg_we,
                alu_src_a, alu_src_b, result_src, alu_op, retire, illegal};

  task automatic chk(input string nm, input int a, input int x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, a, x);
    end
  endtask

  // One clock: drive inputs after the edge, compare all outputs mid-cycle.
  task automatic cyc(input ov_t e, input logic mr, input logic zr);
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero      = zr;
    @(negedge clk);
    ncyc++;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL outputs cyc%0d got %05h want %05h", ncyc, act, e);
    end
    if (act.retire === 1'b1) begin
      last_len = cnt + 1;
      cnt = 0;
    end else begin
      cnt++;
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  // cls: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 illegal
  task automatic run(input int cls, input int fw, input int mw, input logic zr,
                     input logic [2:0] f3, input logic [6:0] bad_op);
    ov_t e;
    logic [6:0] ops [0:5];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    opcode   = (cls == 6) ? bad_op : ops[cls];
    funct3   = f3;
    funct7b5 = rb();
    last_len = -1;
    e = '0; e.mem_req = 1; e.b = 2'b10; e.rs = 2'b10;
    for (int i = 0; i < fw; i++) cyc(e, 1'b0, rb());
    e.pc_en = 1; e.ir_en = 1;
    cyc(e, 1'b1, rb());
    e = '0; e.rd_en = 1; e.alu_en = 1; e.a = 2'b01; e.b = 2'b01;
    cyc(e, rb(), rb());
    case (cls)
      0, 1: begin
        e = '0; e.alu_en = 1; e.a = 2'b10; e.b = 2'b01;
        cyc(e, rb(), rb());
        e = '0; e.mem_req = 1; e.adr_src = 1; e.mem_we = (cls == 1);
        for (int i = 0; i < mw; i++) cyc(e, 1'b0, rb());
        if (cls == 0) e.data_en = 1; else e.retire = 1;
        cyc(e, 1'b1, rb());
        if (cls == 0) begin
          e = '0; e.reg_we = 1; e.rs = 2'b01; e.retire = 1;
          cyc(e, rb(), rb());
        end
      end
      2, 3, 5: begin
        e = '0; e.alu_en = 1;
        if (cls == 5) begin e.pc_en = 1; e.a = 2'b01; e.b = 2'b10; end
        else begin e.a = 2'b10; e.b = (cls == 3) ? 2'b01 : 2'b00; e.op = 2'b10; end
        cyc(e, rb(), rb());
        e = '0; e.reg_we = 1; e.retire = 1;
        cyc(e, rb(), rb());
      end
      4: begin
        e = '0; e.a = 2'b10; e.op = 2'b01; e.retire = 1;
        e.pc_en = (f3 == 3'b000) ? zr : (f3 == 3'b001) ? ~zr : 1'b0;
        cyc(e, rb(), zr);
      end
      default: begin
        e = '0; e.illegal = 1;
        for (int i = 0; i < 20; i++) begin
          opcode = 7'($urandom);
          cyc(e, rb(), rb());
        end
      end
    endcase
  endtask

  // Asynchronous reset pulse dropped mid-cycle while sitting in a memory state.
  task automatic do_reset(input logic mr);
    @(posedge clk);
    #3;
    mem_ready = mr;
    rst_n = 1'b0;
    #1;
    chk("rst mem_req", int'(mem_req), 0);
    chk("rst pc_en|ir_en", int'(pc_en | ir_en), 0);
    chk("rst other_en", int'(mem_we | data_en | rd_en | alu_en | reg_we | retire), 0);
    chk("rst illegal", int'(illegal), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post-rst mem_req", int'(mem_req), 1);
    chk("post-rst pc_en", int'(pc_en), 0);
    cnt = 0;
  endtask

  initial begin
    logic [6:0] bad;
    int cls;
    repeat (3) @(posedge clk);
    #2;
    chk("init illegal", int'(illegal), 0);
    chk("init mem_req", int'(mem_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Park in FETCH with a stalled memory, then reset mid-access.
    opcode = 7'b0000011;
    cyc(ov_t'({9'b100000000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00}), 1'b0, 1'b0);
    do_reset(1'b0);

    run(0, 0, 0, 1'b0, 3'd2, 7'd0); chk("lw len", last_len, 5);
    run(1, 0, 3, 1'b0, 3'd2, 7'd0); chk("sw 3wait len", last_len, 7);
    run(4, 0, 0, 1'b1, 3'd0, 7'd0); chk("beq len", last_len, 3);
    run(4, 0, 0, 1'b1, 3'd1, 7'd0); chk("bne len", last_len, 3);
    run(5, 0, 0, 1'b0, 3'd0, 7'd0); chk("jal len", last_len, 4);
    run(2, 0, 0, 1'b0, 3'd0, 7'd0); chk("R len", last_len, 4);
    run(0, 2, 1, 1'b0, 3'd2, 7'd0); chk("lw 2+1 wait len", last_len, 8);

    for (int n = 0; n < 250; n++) begin
      cls = $urandom_range(0, 5);
      run(cls, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
          rb(), 3'($urandom), 7'd0);
    end

    // Reset while memory is signalling ready: no write enable may fire.
    opcode = 7'b0110011;
    cyc(ov_t'({9'b100000000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00}), 1'b0, 1'b0);
    do_reset(1'b1);

    run(6, 0, 0, 1'b0, 3'd0, 7'b0000000);
    chk("trap illegal held", int'(illegal), 1);
    do_reset(1'b0);
    run(3, 1, 0, 1'b0, 3'd0, 7'd0); chk("I after trap len", last_len, 5);

    for (int n = 0; n < 3; n++) begin
      do bad = 7'($urandom); while (is_legal(bad));
      run(6, $urandom_range(0, 2), 0, 1'b0, 3'd0, bad);
      do_reset(rb());
    end
    run(1, 0, 0, 1'b0, 3'd0, 7'd0); chk("sw len", last_len, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control state machine for the multi-cycle RV32I core. It sequences the shared datapath one instruction at a time: PC, instruction register, memory-data register, rd1/rd2 operand registers, ALU-result register, register file and unified memory port. Each cycle it drives the register write enables, mux selects and memory request. It waits on a memory-ready handshake for every memory access. Instantiated once in the core top, between the datapath and the memory interface.

## Interface
Parameters:
- RESET_STATE_FETCH, 1, reset enters FETCH (0 reserved for debug-halt builds; only 1 is supported).

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instr_reg[6:0]
- funct3  in  3  instr_reg[14:12]
- funct7b5  in  1  instr_reg[30]
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- adr_src  out  1  0 = PC, 1 = alu_reg
- pc_en  out  1  PC write enable
- ir_en  out  1  instr_reg and old_pc enable
- data_en  out  1  data_reg enable
- rd_en  out  1  rd1_reg/rd2_reg enable
- alu_en  out  1  alu_reg enable
- reg_we  out  1  register-file write
- alu_src_a  out  2  00 PC, 01 old_pc, 10 rd1_reg
- alu_src_b  out  2  00 rd2_reg, 01 imm, 10 const 4
- result_src  out  2  00 alu_reg, 01 data_reg, 10 ALU output
- alu_op  out  2  00 add, 01 sub, 10 decode funct3/funct7b5 (funct7b5 honoured only for R-type)
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky, high in TRAP

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, TRAP.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_en=pc_en=mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: rd_en=1, alu_en=1 with old_pc+imm (alu_src_a=01, alu_src_b=01, add). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> TRAP
- MEM_ADR: alu_en=1, rd1_reg+imm. Go to MEM_READ if opcode[5]=0, else MEM_WRITE.
- MEM_READ: mem_req=1, adr_src=1. data_en=mem_ready. Advance to MEM_WB on mem_ready.
- MEM_WB: reg_we=1, result_src=01, retire=1. Go to FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready: retire=1, go to FETCH.
- EXEC_R: rd1 op rd2, alu_op=10, alu_en=1. Go to ALU_WB.
- EXEC_I: rd1 op imm, alu_op=10, alu_en=1. Go to ALU_WB.
- ALU_WB: reg_we=1, result_src=00, retire=1. Go to FETCH.
- BRANCH: rd1 − rd2 (alu_op=01), result_src=00.
  - pc_en = zero when funct3=000; pc_en = ~zero when funct3=001; pc_en = 0 for other funct3.
  - retire=1. Go to FETCH.
- JAL: pc_en=1, result_src=00 (target). alu_en=1 with old_pc+4. Go to ALU_WB.
- TRAP: all enables 0, illegal=1. Held until reset.
- Every output not listed for a state is 0.

## Timing
- Reset (async, rst_n low): state=FETCH. All outputs 0 except the FETCH-state outputs (mem_req=1 once rst_n deasserts). illegal=0.
- Outputs are Moore decodes of state, except ir_en, pc_en, data_en and retire in memory states (gated by mem_ready) and BRANCH pc_en (gated by zero).
- Zero-wait memory gives these cycles per instruction: lw 5, sw 4, R/I 4, branch 3, jal 4. Each wait cycle adds 1.
- mem_req stays high with constant adr_src/mem_we until the mem_ready cycle. mem_ready outside a request is ignored.
- Reset mid-access drops mem_req asynchronously; no write enable fires in the reset cycle.

## Structure
- A shared package `core_ctrl_pkg` holds:
  - state encoding (4-bit, FETCH=0)
  - opcode constants
  - mux-select constants for alu_src_a/b, result_src and alu_op
- No sub-module; the ALU-decoder stays in the datapath.

## Test plan
- Reset mid-FETCH with mem_ready=0 -> state FETCH, pc_en=ir_en=0, illegal=0, mem_req=1 on the first cycle after release.
- lw, zero-wait -> state sequence FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB. data_en and reg_we each high exactly 1 cycle; retire in cycle 5.
- sw with 3 wait cycles -> mem_req/mem_we held 4 cycles, retire on the mem_ready cycle; 7 cycles total.
- beq with zero=1, then bne with zero=1 -> pc_en=1 then pc_en=0 in BRANCH; 3 cycles each.
- jal -> pc_en in FETCH and JAL; reg_we in ALU_WB with result_src=00; 4 cycles.
- opcode 0000000 -> TRAP after DECODE; illegal=1 and no enables for 20 cycles; cleared only by rst_n.
